alu_32: RTL and testbench
=========================

ALU_32 -- requirements
Module: alu_32

Interface
REQ-001 alu_32 SHALL have exactly the ports listed in REQ-002 to REQ-010 and no parameters; data width is fixed at 32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all registered outputs immediately.
REQ-004 a  input  32  operand A.
REQ-005 b  input  32  operand B.
REQ-006 selector  input  3  operation select per REQ-011.
REQ-007 out  output  32  registered result.
REQ-008 carryflag  output  1  registered adder carry-out.
REQ-009 overflag  output  1  registered signed-overflow flag.
REQ-010 zeroflag  output  1  registered flag, 1 when the registered out is zero.

Function
REQ-011 selector decode SHALL be: 000 ADD a+b; 001 SUB a-b; 010 XOR; 011 SLT; 100 AND; 101 NAND; 110 NOR; 111 OR (bitwise ops per bit of a, b).
REQ-012 ADD/SUB SHALL use one 32-bit adder: SUB computes a + ~b + 1; result is modulo 2^32.
REQ-013 carryflag SHALL be the carry out of bit 31 for ADD and SUB; for SUB, 1 means no borrow (a >= b unsigned).
REQ-014 overflag SHALL be 1 for ADD when a[31]==b[31] and result[31]!=a[31], and for SUB when a[31]!=b[31] and result[31]!=a[31].
REQ-015 SLT SHALL output 32'h00000001 when a < b as unsigned, else 32'h00000000.
REQ-016 For selector 010, 011, 100, 101, 110 and 111, carryflag and overflag SHALL be 0.
REQ-017 zeroflag SHALL be 1 exactly when the 32-bit result being registered equals 0, for every operation.
REQ-018 Result and flags SHALL be computed combinationally from a, b and selector and captured on each rising clk edge, giving a latency of 1 cycle.
REQ-019 A new operation SHALL be accepted every cycle; there is no handshake and no stall.
REQ-020 Changing selector or operands between edges SHALL affect only the value captured at the next edge.

Reset
REQ-021 While reset is high, out SHALL be 0, carryflag 0, overflag 0 and zeroflag 1, independent of clk.
REQ-022 Reset asserted mid-operation SHALL discard the pending result; the first capture SHALL occur on the first rising edge after reset deasserts.

Verification
REQ-023 ADD: a=7FFFFFFF, b=7FFFFFFF -> out=FFFFFFFE, carry=0, overflow=1, zero=0.
REQ-024 ADD: a=80000000, b=80000000 -> out=00000000, carry=1, overflow=1, zero=1; ADD FFFFFFFF+FFFFFFFF -> FFFFFFFE, carry=1, overflow=0.
REQ-025 SUB: a=0, b=1 -> out=FFFFFFFF, carry=0, overflow=0; a=80000000, b=00000001 -> out=7FFFFFFF, carry=1, overflow=1; a=b=C8380861 -> out=0, carry=1, zero=1.
REQ-026 SLT: a=55555555, b=AAAAAAAA -> 00000001; a=0000F000, b=0000EFFF -> 00000000, zero=1; a=b=FFFFFFFF -> 00000000.
REQ-027 Logic: a=D4A2E712, b=2994AE4B -> AND 0080A602, NAND FF7F59FD, NOR 02491 0A4 (=024910A4), OR FDB6EF5B, XOR FD3649 59 (=FD364959); carry=0, overflow=0 in all cases.
REQ-028 Reset: assert reset after an ADD giving FFFFFFFE, without a clock edge -> out=0, carry=0, overflow=0, zero=1 immediately; after deassert, output follows the inputs after 1 cycle.

Source files
------------

// File: rtl/alu_32.sv
// alu_32: 32-bit registered ALU. Eight operations with carry, signed overflow
// and zero flags. The result is computed combinationally and captured on each
// rising clock edge, so every result appears one cycle after its inputs.
module alu_32 (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  selector,
  output logic [31:0] out,
  output logic        carryflag,
  output logic        overflag,
  output logic        zeroflag
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_XOR  = 3'b010,
    OP_SLT  = 3'b011,
    OP_AND  = 3'b100,
    OP_NAND = 3'b101,
    OP_NOR  = 3'b110,
    OP_OR   = 3'b111
  } op_e;

  op_e         op;
  logic        is_sub;
  logic [31:0] b_eff;
  logic [32:0] sum;
  logic [31:0] result;
  logic        carry;
  logic        overflow;

  assign op = op_e'(selector);

  // ADD and SUB share one adder. SUB is a + ~b + 1.
  always_comb begin
    is_sub = (op == OP_SUB);
    b_eff  = is_sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + {32'd0, is_sub};
  end

  // Select the result for this cycle. Flags stay 0 for the non-arithmetic ops.
  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    unique case (op)
      OP_ADD: begin
        result   = sum[31:0];
        carry    = sum[32];
        overflow = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      OP_SUB: begin
        result   = sum[31:0];
        carry    = sum[32];
        overflow = (a[31] != b[31]) && (sum[31] != a[31]);
      end
      OP_XOR:  result = a ^ b;
      OP_SLT:  result = {31'd0, (a < b)};
      OP_AND:  result = a & b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_OR:   result = a | b;
      default: result = '0;
    endcase
  end

  // Capture the result and flags. Reset clears them at once; zero reads 1 because out is 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out       <= '0;
      carryflag <= 1'b0;
      overflag  <= 1'b0;
      zeroflag  <= 1'b1;
    end else begin
      out       <= result;
      carryflag <= carry;
      overflag  <= overflow;
      zeroflag  <= (result == 32'd0);
    end
  end

endmodule

// File: tb/tb_alu_32.sv
// tb_alu_32: directed-vector bench for alu_32 with hand-computed expected values.
module tb_alu_32;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  selector;
  logic [31:0] out;
  logic        carryflag;
  logic        overflag;
  logic        zeroflag;

  int unsigned checks_total;
  int unsigned checks_passed;

  alu_32 dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .selector  (selector),
    .out       (out),
    .carryflag (carryflag),
    .overflag  (overflag),
    .zeroflag  (zeroflag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks_total++;
    if (observed === expected) checks_passed++;
    else $display("FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  // Drive at the falling edge, sample 1 time unit after the next rising edge.
  task automatic run_op(input string tag, input logic [2:0] sel, input logic [31:0] op_a,
                        input logic [31:0] op_b, input logic [31:0] exp_out,
                        input logic exp_c, input logic exp_v, input logic exp_z);
    @(negedge clk);
    selector = sel;
    a        = op_a;
    b        = op_b;
    @(posedge clk);
    #1;
    check({tag, ".out"}, out, exp_out);
    check({tag, ".cvz"}, {29'd0, carryflag, overflag, zeroflag}, {29'd0, exp_c, exp_v, exp_z});
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    reset    = 1'b1;
    a        = 32'h1234_5678;
    b        = 32'h1111_1111;
    selector = 3'b000;

    // Reset held across clock edges keeps outputs cleared.
    repeat (2) @(posedge clk);
    #1;
    check("reset.out", out, 32'h0);
    check("reset.cvz", {29'd0, carryflag, overflag, zeroflag}, 32'h1);

    @(negedge clk);
    reset = 1'b0;

    // ADD
    run_op("add_small",  3'b000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 0, 0, 0);
    run_op("add_pos_ov", 3'b000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 0, 1, 0);
    run_op("add_neg_ov", 3'b000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1, 1, 1);
    run_op("add_ff_ff",  3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 0, 0);
    run_op("add_wrap",   3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0, 1);

    // SUB
    run_op("sub_borrow", 3'b001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 0, 0, 0);
    run_op("sub_ov",     3'b001, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1, 1, 0);
    run_op("sub_eq",     3'b001, 32'hC838_0861, 32'hC838_0861, 32'h0000_0000, 1, 0, 1);
    run_op("sub_small",  3'b001, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1, 0, 0);

    // SLT (unsigned)
    run_op("slt_lt",     3'b011, 32'h5555_5555, 32'hAAAA_AAAA, 32'h0000_0001, 0, 0, 0);
    run_op("slt_gt",     3'b011, 32'h0000_F000, 32'h0000_EFFF, 32'h0000_0000, 0, 0, 1);
    run_op("slt_eq",     3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, 0, 1);

    // Logic ops; flags forced to 0 even with inputs that would carry/overflow on ADD.
    run_op("and",  3'b100, 32'hD4A2_E712, 32'h2994_AE4B, 32'h0080_A602, 0, 0, 0);
    run_op("nand", 3'b101, 32'hD4A2_E712, 32'h2994_AE4B, 32'hFF7F_59FD, 0, 0, 0);
    run_op("nor",  3'b110, 32'hD4A2_E712, 32'h2994_AE4B, 32'h0249_10A4, 0, 0, 0);
    run_op("or",   3'b111, 32'hD4A2_E712, 32'h2994_AE4B, 32'hFDB6_EF5B, 0, 0, 0);
    run_op("xor",  3'b010, 32'hD4A2_E712, 32'h2994_AE4B, 32'hFD36_4959, 0, 0, 0);
    run_op("xor_z",3'b010, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 0, 0, 1);

    // Inputs changed between edges must not affect out until the next edge.
    run_op("hold_pre", 3'b000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 0, 1, 0);
    @(negedge clk);
    selector = 3'b100;
    a        = 32'h0000_0000;
    b        = 32'h0000_0000;
    #2;
    check("hold.out", out, 32'hFFFF_FFFE);
    check("hold.cvz", {29'd0, carryflag, overflag, zeroflag}, 32'h2);

    // Asynchronous reset without a clock edge after an ADD giving FFFFFFFE.
    run_op("rst_pre", 3'b000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 0, 1, 0);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst.out", out, 32'h0);
    check("async_rst.cvz", {29'd0, carryflag, overflag, zeroflag}, 32'h1);

    // Release between edges: outputs stay cleared until the next rising edge captures.
    @(negedge clk);
    selector = 3'b111;
    a        = 32'hF000_0000;
    b        = 32'h0000_000F;
    reset    = 1'b0;
    #1;
    check("post_rst_wait.out", out, 32'h0);
    @(posedge clk);
    #1;
    check("post_rst.out", out, 32'hF000_000F);
    check("post_rst.cvz", {29'd0, carryflag, overflag, zeroflag}, 32'h0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
